// File: rtl/sys_clken_gen_pkg.sv
// Shared types and helpers for the sys_clken_gen clock-enable generator.
// The FSM state encoding, the per-channel configuration record and the
// counter load-value helper live here so the top and channel agree on them.
package sys_clken_gen_pkg;

    // Default field width of the configuration record.
    localparam int PKG_CNT_W = 16;

    // Widest counter supported by the shared load helper.
    localparam int CNT_MAX_W = 32;

    typedef enum logic [1:0] {
        ALIGN  = 2'd0,
        SETTLE = 2'd1,
        LOCKED = 2'd2
    } state_t;

    typedef struct packed {
        logic [PKG_CNT_W-1:0] div;
        logic [PKG_CNT_W-1:0] phase;
        logic [PKG_CNT_W-1:0] high;
    } chan_cfg_t;

    // Counter value loaded during ALIGN. A counter loaded with div-phase
    // reaches zero, and so strobes, exactly phase cycles later.
    function automatic logic [CNT_MAX_W-1:0] calc_load(
        input logic [CNT_MAX_W-1:0] div,
        input logic [CNT_MAX_W-1:0] phase
    );
        logic [CNT_MAX_W-1:0] load;
        if (phase == {CNT_MAX_W{1'b0}}) begin
            load = {CNT_MAX_W{1'b0}};
        end else begin
            load = div - phase;
        end
        return load;
    endfunction

endpackage

// File: rtl/sys_clken_gen_chan.sv
// One output channel of sys_clken_gen: configuration registers, the free
// running period counter and the registered square-wave / strobe outputs.
// CNT_W may be at most 32 (the width of the shared load helper).
module sys_clken_gen_chan
    import sys_clken_gen_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int DEF_DIV   = 2,
    parameter int DEF_PHASE = 0,
    parameter int DEF_HIGH  = 1
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             i_align,
    input  logic             i_wr_en,
    input  logic [CNT_W-1:0] i_div,
    input  logic [CNT_W-1:0] i_phase,
    input  logic [CNT_W-1:0] i_high,
    output logic             o_clk,
    output logic             o_en
);

    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_phase;
    logic [CNT_W-1:0] r_high;
    logic [CNT_W-1:0] r_cnt;
    logic             r_clk;
    logic             r_en;
    logic [CNT_W-1:0] w_load;
    logic [CNT_W-1:0] w_cnt_nxt;

    // Alignment load value and the wrapping increment of the period counter.
    always_comb begin
        w_load = CNT_W'(calc_load(CNT_MAX_W'(r_div), CNT_MAX_W'(r_phase)));
        if (r_cnt >= (r_div - CNT_W'(1'b1))) begin
            w_cnt_nxt = {CNT_W{1'b0}};
        end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1'b1);
        end
    end

    // Channel configuration registers, written by accepted valid writes.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_div   <= CNT_W'(DEF_DIV);
            r_phase <= CNT_W'(DEF_PHASE);
            r_high  <= CNT_W'(DEF_HIGH);
        end else if (i_wr_en) begin
            r_div   <= i_div;
            r_phase <= i_phase;
            r_high  <= i_high;
        end else begin
            r_div   <= r_div;
            r_phase <= r_phase;
            r_high  <= r_high;
        end
    end

    // Period counter plus outputs decoded from the previous counter value.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= {CNT_W{1'b0}};
            r_clk <= 1'b0;
            r_en  <= 1'b0;
        end else if (i_align) begin
            r_cnt <= w_load;
            r_clk <= 1'b0;
            r_en  <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_clk <= (r_cnt < r_high);
            r_en  <= (r_cnt == {CNT_W{1'b0}});
        end
    end

    assign o_clk = r_clk;
    assign o_en  = r_en;

endmodule

// File: rtl/sys_clken_gen.sv
// sys_clken_gen: runtime-reconfigurable multi-channel clock-enable generator.
// Owns the ALIGN/SETTLE/LOCKED state machine, the configuration handshake and
// the locked flag; the channels themselves live in sys_clken_gen_chan.
// Optional feature macro: SYS_CLKEN_GEN_LOCK_LOSS_CNT_EN adds a saturating
// 16-bit lock_loss_cnt output counting 1->0 transitions of locked.
module sys_clken_gen
    import sys_clken_gen_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int CNT_W      = 16,
    parameter int SETTLE_CYC = 256,
    parameter int DEF_DIV    = 2,
    parameter int DEF_PHASE  = 0,
    parameter int DEF_HIGH   = 1,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [CNT_W-1:0]  cfg_phase,
    input  logic [CNT_W-1:0]  cfg_high,
    output logic              cfg_err,
    input  logic              resync,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] en_out,
    output logic              locked
`ifdef SYS_CLKEN_GEN_LOCK_LOSS_CNT_EN
    ,
    output logic [15:0]       lock_loss_cnt
`endif
);

    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    state_t             r_state;
    logic [SET_W-1:0]   r_settle;
    logic               r_locked;
    logic               r_cfg_ready;
    logic               r_cfg_err;
    logic               w_wr_acc;
    logic               w_cfg_bad;
    logic               w_wr_ok;
    logic               w_realign;
    logic               w_align;
    logic [NUM_CH-1:0]  w_wr_en;

    // Handshake decode: which writes are accepted, rejected, and what realigns.
    always_comb begin
        w_wr_acc  = cfg_valid & r_cfg_ready;
        w_cfg_bad = (cfg_div == {CNT_W{1'b0}})
                  | (cfg_phase >= cfg_div)
                  | (32'(cfg_ch) >= 32'(NUM_CH));
        w_wr_ok   = w_wr_acc & ~w_cfg_bad;
        w_realign = w_wr_ok | (resync & r_cfg_ready);
        w_align   = (r_state == ALIGN);
    end

    // Alignment state machine with registered locked / ready / error flags.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ALIGN;
            r_settle    <= {SET_W{1'b0}};
            r_locked    <= 1'b0;
            r_cfg_ready <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_cfg_err <= w_wr_acc & w_cfg_bad;
            case (r_state)
                ALIGN: begin
                    r_state     <= SETTLE;
                    r_settle    <= {SET_W{1'b0}};
                    r_cfg_ready <= 1'b1;
                    r_locked    <= 1'b0;
                end
                SETTLE: begin
                    if (w_realign) begin
                        r_state     <= ALIGN;
                        r_cfg_ready <= 1'b0;
                        r_locked    <= 1'b0;
                    end else if (r_settle == SET_W'(SETTLE_CYC - 1)) begin
                        r_state  <= LOCKED;
                        r_locked <= 1'b1;
                    end else begin
                        r_settle <= r_settle + SET_W'(1'b1);
                    end
                end
                LOCKED: begin
                    if (w_realign) begin
                        r_state     <= ALIGN;
                        r_cfg_ready <= 1'b0;
                        r_locked    <= 1'b0;
                    end else begin
                        r_locked <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ALIGN;
                    r_cfg_ready <= 1'b0;
                    r_locked    <= 1'b0;
                end
            endcase
        end
    end

`ifdef SYS_CLKEN_GEN_LOCK_LOSS_CNT_EN
    logic        w_lock_drop;
    logic [15:0] r_lock_loss_cnt;

    // locked only ever falls when a realign leaves the LOCKED state.
    always_comb begin
        w_lock_drop = (r_state == LOCKED) & w_realign;
    end

    // Saturating count of lock losses.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_loss_cnt <= 16'd0;
        end else if (w_lock_drop && (r_lock_loss_cnt != 16'hFFFF)) begin
            r_lock_loss_cnt <= r_lock_loss_cnt + 16'd1;
        end else begin
            r_lock_loss_cnt <= r_lock_loss_cnt;
        end
    end

    assign lock_loss_cnt = r_lock_loss_cnt;
`endif

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_chan
            assign w_wr_en[g] = w_wr_ok & (cfg_ch == CH_W'(g));

            sys_clken_gen_chan #(
                .CNT_W     (CNT_W),
                .DEF_DIV   (DEF_DIV),
                .DEF_PHASE (DEF_PHASE),
                .DEF_HIGH  (DEF_HIGH)
            ) u_chan (
                .refclk  (refclk),
                .rst_n   (rst_n),
                .i_align (w_align),
                .i_wr_en (w_wr_en[g]),
                .i_div   (cfg_div),
                .i_phase (cfg_phase),
                .i_high  (cfg_high),
                .o_clk   (clk_out[g]),
                .o_en    (en_out[g])
            );
        end
    endgenerate

    assign cfg_ready = r_cfg_ready;
    assign cfg_err   = r_cfg_err;
    assign locked    = r_locked;

endmodule
